eth_frame_pattern_matcher: RTL

- Parametrised successor to the frame detector datapath. Compares every received Ethernet frame byte-wise against C_NUM_PATTERNS programmable, byte-masked patterns of C_PATTERN_LEN bytes.
- Reports one result per frame: per-pattern match vector, SOF timestamp, frame length and bad-frame flag.
- Sits between the TEMAC RX stream tap and the log/loopback logic, in the single RX clock domain.

---
 rtl/eth_frame_pattern_pkg.sv | 29 ++
 rtl/eth_frame_pattern_mem.sv | 47 ++++
 rtl/eth_frame_pattern_matcher.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_pattern_pkg.sv
// Shared types for the frame pattern matcher: FSM states, config address
// width helper and the per-frame result record.
package eth_frame_pattern_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_SKIP  = 2'd2
  } state_t;

  localparam int unsigned C_MAX_PATTERNS  = 16;
  localparam int unsigned C_MAX_LEN_WIDTH = 32;

  function automatic int unsigned cfg_addr_width(input int unsigned num_patterns,
                                                 input int unsigned pattern_len);
    return $clog2(num_patterns * pattern_len);
  endfunction

  localparam int unsigned C_CFG_ADDR_W = cfg_addr_width(4, 64);

  // Sized for the largest supported configuration; narrower builds use the low bits.
  typedef struct packed {
    logic [C_MAX_PATTERNS-1:0]  mask;
    logic [63:0]                ts;
    logic [C_MAX_LEN_WIDTH-1:0] len;
    logic                       bad;
  } result_t;

endpackage

// File: rtl/eth_frame_pattern_mem.sv
// One pattern's storage: C_PATTERN_LEN entries of {mask, byte}, synchronous
// write, combinational read so the compare happens in the beat's own cycle.
module eth_frame_pattern_mem #(
  parameter int unsigned C_PATTERN_LEN = 64,
  parameter int unsigned C_IDX_W       = $clog2(C_PATTERN_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [C_IDX_W-1:0]       wr_idx,
  input  logic [7:0]               wr_data,
  input  logic                     wr_mask,
  input  logic [C_IDX_W-1:0]       rd_idx,
  output logic [7:0]               rd_data,
  output logic                     rd_mask,
  output logic [C_PATTERN_LEN-1:0] mask_bits
);

  logic [8:0] mem_q [C_PATTERN_LEN];
  logic [8:0] mem_d [C_PATTERN_LEN];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = {wr_mask, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < C_PATTERN_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_data = mem_q[rd_idx][7:0];
    rd_mask = mem_q[rd_idx][8];
    for (int unsigned i = 0; i < C_PATTERN_LEN; i++) begin
      mask_bits[i] = mem_q[i][8];
    end
  end

endmodule

// File: rtl/eth_frame_pattern_matcher.sv
// Byte-wise masked pattern matcher on the RX stream; one result per frame.
// Optional macro ETH_FRAME_PATTERN_EARLY_EN adds the early_match output.
module eth_frame_pattern_matcher
  import eth_frame_pattern_pkg::*;
#(
  parameter int unsigned C_NUM_PATTERNS = 4,
  parameter int unsigned C_PATTERN_LEN  = 64,
  parameter int unsigned C_LEN_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tuser,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  input  logic                      enable,
  input  logic [63:0]               current_time,
  input  logic                      cfg_wr,
  input  logic [cfg_addr_width(C_NUM_PATTERNS, C_PATTERN_LEN)-1:0] cfg_addr,
  input  logic [7:0]                cfg_data,
  input  logic                      cfg_mask,
  input  logic                      cfg_en_wr,
  input  logic [C_NUM_PATTERNS-1:0] cfg_en_data,
  output logic                      cfg_busy,
  output logic                      match_valid,
  output logic [C_NUM_PATTERNS-1:0] match_mask,
  output logic [63:0]               match_time,
  output logic [C_LEN_WIDTH-1:0]    match_len,
  output logic                      match_bad
`ifdef ETH_FRAME_PATTERN_EARLY_EN
  ,
  output logic [C_NUM_PATTERNS-1:0] early_match
`endif
);

  localparam int unsigned AW = cfg_addr_width(C_NUM_PATTERNS, C_PATTERN_LEN);
  localparam int unsigned IW = $clog2(C_PATTERN_LEN + 1);
  localparam int unsigned RW = $clog2(C_PATTERN_LEN);

  state_t state_q, state_d;

  logic [IW-1:0]             idx_q, idx_d, cur_idx;
  logic [C_NUM_PATTERNS-1:0] alive_q, alive_d, cur_alive, alive_next;
  logic [C_LEN_WIDTH-1:0]    len_q, len_d, cur_len, len_next;
  logic [63:0]               time_q, time_d, cur_time;
  logic [C_NUM_PATTERNS-1:0] en_q, en_d;

  logic                      match_valid_q, match_valid_d;
  logic [C_NUM_PATTERNS-1:0] match_mask_q, match_mask_d;
  logic [63:0]               match_time_q, match_time_d;
  logic [C_LEN_WIDTH-1:0]    match_len_q, match_len_d;
  logic                      match_bad_q, match_bad_d;

  logic                      sof, active, cfg_ok, in_win;
  logic [RW-1:0]             rd_idx;
  logic [C_NUM_PATTERNS-1:0] mismatch, short_fail, pat_mask;
  logic [C_PATTERN_LEN-1:0]  tail;
  logic [7:0]                pat_data [C_NUM_PATTERNS];
  logic [C_PATTERN_LEN-1:0]  pat_bits [C_NUM_PATTERNS];

  for (genvar p = 0; p < C_NUM_PATTERNS; p++) begin : g_pat
    localparam int unsigned BASE = p * C_PATTERN_LEN;
    logic [31:0] off;
    logic        hit;
    // Unsigned wrap makes addresses below BASE land far out of range.
    assign off = 32'(cfg_addr) - BASE;
    assign hit = off < C_PATTERN_LEN;

    eth_frame_pattern_mem #(
      .C_PATTERN_LEN(C_PATTERN_LEN),
      .C_IDX_W      (RW)
    ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (cfg_ok && cfg_wr && hit),
      .wr_idx   (off[RW-1:0]),
      .wr_data  (cfg_data),
      .wr_mask  (cfg_mask),
      .rd_idx   (rd_idx),
      .rd_data  (pat_data[p]),
      .rd_mask  (pat_mask[p]),
      .mask_bits(pat_bits[p])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid && !s_axis_tlast) begin
          state_d = enable ? S_FRAME : S_SKIP;
        end
      end
      S_FRAME, S_SKIP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_busy = (state_q != S_IDLE);
  end

  // The SOF beat is compared in its own cycle, so per-frame state is taken
  // from its start values rather than the registers while idle.
  always_comb begin
    sof       = (state_q == S_IDLE) && s_axis_tvalid;
    active    = (state_q == S_FRAME) || (sof && enable);
    cfg_ok    = (state_q == S_IDLE) && !s_axis_tvalid;
    cur_idx   = (state_q == S_IDLE) ? '0 : idx_q;
    cur_alive = (state_q == S_IDLE) ? en_q : alive_q;
    cur_len   = (state_q == S_IDLE) ? '0 : len_q;
    cur_time  = (state_q == S_IDLE) ? current_time : time_q;
    in_win    = cur_idx < IW'(C_PATTERN_LEN);
    rd_idx    = in_win ? RW'(cur_idx) : RW'(C_PATTERN_LEN - 1);

    for (int unsigned j = 0; j < C_PATTERN_LEN; j++) begin
      tail[j] = IW'(j) > cur_idx;
    end
    for (int unsigned p = 0; p < C_NUM_PATTERNS; p++) begin
      mismatch[p]   = in_win && pat_mask[p] && (pat_data[p] != s_axis_tdata);
      short_fail[p] = |(pat_bits[p] & tail);
    end
    alive_next = cur_alive & ~mismatch;
    len_next   = (&cur_len) ? cur_len : cur_len + C_LEN_WIDTH'(1);

    idx_d         = idx_q;
    alive_d       = alive_q;
    len_d         = len_q;
    time_d        = time_q;
    match_valid_d = 1'b0;
    match_mask_d  = match_mask_q;
    match_time_d  = match_time_q;
    match_len_d   = match_len_q;
    match_bad_d   = match_bad_q;
    en_d          = (cfg_ok && cfg_en_wr) ? cfg_en_data : en_q;

    if (s_axis_tvalid) begin
      idx_d   = in_win ? cur_idx + IW'(1) : cur_idx;
      alive_d = alive_next;
      len_d   = len_next;
      time_d  = cur_time;
      if (s_axis_tlast && active) begin
        match_valid_d = 1'b1;
        match_mask_d  = s_axis_tuser ? '0 : (alive_next & ~short_fail);
        match_time_d  = cur_time;
        match_len_d   = len_next;
        match_bad_d   = s_axis_tuser;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      alive_q       <= '0;
      len_q         <= '0;
      time_q        <= '0;
      en_q          <= '0;
      match_valid_q <= 1'b0;
      match_mask_q  <= '0;
      match_time_q  <= '0;
      match_len_q   <= '0;
      match_bad_q   <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      alive_q       <= alive_d;
      len_q         <= len_d;
      time_q        <= time_d;
      en_q          <= en_d;
      match_valid_q <= match_valid_d;
      match_mask_q  <= match_mask_d;
      match_time_q  <= match_time_d;
      match_len_q   <= match_len_d;
      match_bad_q   <= match_bad_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_mask  = match_mask_q;
  assign match_time  = match_time_q;
  assign match_len   = match_len_q;
  assign match_bad   = match_bad_q;

`ifdef ETH_FRAME_PATTERN_EARLY_EN
  logic [C_NUM_PATTERNS-1:0] early_q, early_d;

  always_comb begin
    early_d = '0;
    if (s_axis_tvalid && active && (cur_idx == IW'(C_PATTERN_LEN - 1))) begin
      early_d = alive_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      early_q <= '0;
    end else begin
      early_q <= early_d;
    end
  end

  assign early_match = early_q;
`endif

endmodule
